// File: rtl/csa_cpa_resolver_if.sv
// Handshake bundle between the last CSA tree stage, the resolver and its consumer.
// master = tree/consumer side, slave = resolver.
interface csa_cpa_resolver_if #(
    parameter int WIDTH = 32
) ();
    logic             v_in;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] carry_in;
    logic             in_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             v_out;
    logic             ready_in;
    logic             err_drop;

    modport master (
        output v_in, sum_in, carry_in, ready_in,
        input  in_ready, result, cout, v_out, err_drop
    );

    modport slave (
        input  v_in, sum_in, carry_in, ready_in,
        output in_ready, result, cout, v_out, err_drop
    );
endinterface

// File: rtl/csa_cpa_resolver.sv
// Resolves a redundant sum/carry pair into binary with a CHUNK-bit-per-cycle
// carry-propagate add, then holds the result under a valid/ready handshake.
module csa_cpa_resolver #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic               clk,
    input logic               rst_n,
    csa_cpa_resolver_if.slave bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    if (WIDTH % CHUNK != 0) begin : g_chunk_check
        $error("csa_cpa_resolver: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state;
    state_t                     state_next;

    logic [N-1:0][CHUNK-1:0]    sum_hold;
    logic [N-1:0][CHUNK-1:0]    carry_hold;
    logic [N-1:0][CHUNK-1:0]    result_q;
    logic [IDX_W-1:0]           idx;
    logic                       c;
    logic                       cout_q;
    logic                       v_out_q;
    logic                       err_q;

    logic                       in_ready;
    logic                       capture;
    logic                       drop;
    logic                       last_chunk;
    logic [CHUNK:0]             chunk_sum;

    // One slice of the carry-propagate add: CHUNK-bit sum plus carry out.
    function automatic logic [CHUNK:0] add_chunk(
        input logic [CHUNK-1:0] a,
        input logic [CHUNK-1:0] b,
        input logic             ci
    );
        add_chunk = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    endfunction

    // A DONE result can be handed off and replaced on the same edge.
    assign in_ready   = (state == IDLE) | ((state == DONE) & bus.ready_in);
    assign capture    = bus.v_in & in_ready;
    assign drop       = bus.v_in & ~in_ready;
    assign last_chunk = (idx == IDX_W'(N - 1));
    assign chunk_sum  = add_chunk(sum_hold[idx], carry_hold[idx], c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (capture) begin
                    state_next = ADD;
                end else if (bus.ready_in) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_hold   <= '0;
            carry_hold <= '0;
            result_q   <= '0;
            idx        <= '0;
            c          <= 1'b0;
            cout_q     <= 1'b0;
            v_out_q    <= 1'b0;
        end else if (capture) begin
            sum_hold   <= bus.sum_in;
            carry_hold <= bus.carry_in;
            idx        <= '0;
            c          <= 1'b0;
            v_out_q    <= 1'b0;
        end else if (state == ADD) begin
            result_q[idx] <= chunk_sum[CHUNK-1:0];
            c             <= chunk_sum[CHUNK];
            idx           <= idx + 1'b1;
            if (last_chunk) begin
                cout_q  <= chunk_sum[CHUNK];
                v_out_q <= 1'b1;
            end
        end else if ((state == DONE) && bus.ready_in) begin
            // result and cout stay as they are after the handoff
            v_out_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (drop) begin
            err_q <= 1'b1;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.v_out    = v_out_q;
    assign bus.err_drop = err_q;
endmodule

// File: tb/tb_csa_cpa_resolver.sv
// Directed and random bench for csa_cpa_resolver: a queue model of the
// handshake/latency contract is compared every cycle, plus hand-computed vectors.
module tb_csa_cpa_resolver;
    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    csa_cpa_resolver_if #(.WIDTH(WIDTH)) bif ();

    csa_cpa_resolver #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    typedef struct {
        logic [WIDTH:0] total;
        int             due;
    } exp_t;

    exp_t q[$];
    int   k       = 0;
    logic exp_err = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_sent   = 0;
    int   n_done   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: a capture is due N edges later, held until a ready_in handoff.
    always @(negedge clk) begin
        logic front_valid;
        logic mdl_ready;
        if (!rst_n) begin
            q.delete();
            exp_err = 1'b0;
        end else begin
            front_valid = (q.size() > 0) && (q[0].due <= k);
            chk("v_out", bif.v_out, front_valid);
            if (front_valid) begin
                chk("result", bif.result, q[0].total[WIDTH-1:0]);
                chk("cout", bif.cout, q[0].total[WIDTH]);
            end
            mdl_ready = (q.size() == 0) || (front_valid && bif.ready_in);
            chk("in_ready", bif.in_ready, mdl_ready);
            chk("err_drop", bif.err_drop, exp_err);
            if (front_valid && bif.ready_in) begin
                void'(q.pop_front());
                n_done++;
            end
            if (bif.v_in) begin
                if (mdl_ready) begin
                    q.push_back('{total: {1'b0, bif.sum_in} + {1'b0, bif.carry_in}, due: k + 1 + N});
                end else begin
                    exp_err = 1'b1;
                end
            end
        end
        k++;
    end

    task automatic send(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] cy);
        bif.v_in     = 1'b1;
        bif.sum_in   = s;
        bif.carry_in = cy;
        n_sent++;
        @(posedge clk);
        #1;
        bif.v_in = 1'b0;
    endtask

    task automatic wait_vout(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bif.v_out && lat < 20);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        bif.v_in     = 1'b0;
        bif.sum_in   = '0;
        bif.carry_in = '0;
        bif.ready_in = 1'b0;
        rst_n        = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_result", bif.result, 0);
        chk("rst_cout", bif.cout, 0);
        chk("rst_v_out", bif.v_out, 0);
        chk("rst_err_drop", bif.err_drop, 0);
        chk("rst_in_ready", bif.in_ready, 1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic add with a carry crossing the first chunk boundary
        bif.ready_in = 1'b1;
        send(32'h0000_00FF, 32'h0000_0001);
        wait_vout(lat);
        chk("basic_latency", lat, 4);
        chk("basic_result", bif.result, 32'h0000_0100);
        chk("basic_cout", bif.cout, 0);
        chk("basic_in_ready", bif.in_ready, 1);
        @(posedge clk);
        #1;
        chk("basic_v_out_drop", bif.v_out, 0);

        // Carry ripples through every chunk
        send(32'hFFFF_FFFF, 32'h0000_0001);
        wait_vout(lat);
        chk("ripple_result", bif.result, 32'h0000_0000);
        chk("ripple_cout", bif.cout, 1);
        @(posedge clk);
        #1;
        send(32'h8000_0000, 32'h8000_0000);
        wait_vout(lat);
        chk("msb_result", bif.result, 32'h0000_0000);
        chk("msb_cout", bif.cout, 1);
        @(posedge clk);
        #1;

        // Back-to-back: new capture on the handoff edge
        send(32'h0000_0010, 32'h0000_0020);
        wait_vout(lat);
        chk("b2b_first_result", bif.result, 32'h0000_0030);
        send(32'h0000_0003, 32'h0000_0004);
        chk("b2b_v_out_low", bif.v_out, 0);
        chk("b2b_in_ready_low", bif.in_ready, 0);
        wait_vout(lat);
        chk("b2b_latency", lat, 4);
        chk("b2b_result", bif.result, 32'h0000_0007);
        @(posedge clk);
        #1;

        // Backpressure with a dropped operand in the hold window
        bif.ready_in = 1'b0;
        send(32'h1234_5678, 32'h1111_1111);
        wait_vout(lat);
        for (int i = 0; i < 6; i++) begin
            chk("bp_v_out", bif.v_out, 1);
            chk("bp_result", bif.result, 32'h2345_6789);
            chk("bp_in_ready", bif.in_ready, 0);
            bif.v_in     = (i == 2);
            bif.sum_in   = 32'hDEAD_BEEF;
            bif.carry_in = 32'h0BAD_F00D;
            @(posedge clk);
            #1;
        end
        bif.v_in = 1'b0;
        chk("bp_err_drop", bif.err_drop, 1);
        chk("bp_result_kept", bif.result, 32'h2345_6789);
        bif.ready_in = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_v_out", bif.v_out, 0);
        chk("bp_release_result", bif.result, 32'h2345_6789);

        // Asynchronous reset during the second ADD cycle
        send(32'h1234_5678, 32'h1111_1111);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_result", bif.result, 0);
        chk("abort_v_out", bif.v_out, 0);
        chk("abort_err_drop", bif.err_drop, 0);
        chk("abort_in_ready", bif.in_ready, 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_v_out", bif.v_out, 0);
        end

        // Random pairs, spaced at least N cycles, random backpressure
        n_sent = 0;
        n_done = 0;
        for (int i = 0; i < 1000; i++) begin
            bif.ready_in = 1'b1;
            send(WIDTH'($urandom), WIDTH'($urandom));
            repeat (4 + $urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
                bif.ready_in = 1'($urandom_range(0, 1));
            end
        end
        bif.ready_in = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        chk("rand_err_drop", bif.err_drop, 0);
        chk("rand_delivered", n_done, n_sent);
        chk("rand_count", n_sent, 1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
